// File: rtl/r200_hazard_ctl_if.sv
// ID-stage hazard control bundle: decode-side inputs, branch/writeback status and pipeline control outputs.
// The pipeline (master) drives the instruction fields; the hazard controller (slave) drives the controls.
interface r200_hazard_ctl_if;
    logic        id_valid;
    logic [4:0]  id_rs1addr;
    logic [4:0]  id_rs2addr;
    logic        id_uses_rs1;
    logic        id_uses_rs2;
    logic [4:0]  id_rdaddr;
    logic        id_regwr;
    logic        id_isbr;
    logic        id_willjmp;
    logic        br_resolve;
    logic        br_taken;
    logic        wb_regwr;
    logic [4:0]  wb_rdaddr;
    logic        stall;
    logic        bubble;
    logic        flush;
    logic        redirect;
    logic        id_fire;
    logic [31:0] pending;

    modport master (
        output id_valid, id_rs1addr, id_rs2addr, id_uses_rs1, id_uses_rs2,
               id_rdaddr, id_regwr, id_isbr, id_willjmp,
               br_resolve, br_taken, wb_regwr, wb_rdaddr,
        input  stall, bubble, flush, redirect, id_fire, pending
    );

    modport slave (
        input  id_valid, id_rs1addr, id_rs2addr, id_uses_rs1, id_uses_rs2,
               id_rdaddr, id_regwr, id_isbr, id_willjmp,
               br_resolve, br_taken, wb_regwr, wb_rdaddr,
        output stall, bubble, flush, redirect, id_fire, pending
    );
endinterface

// File: rtl/r200_hazard_ctl.sv
// R200 hazard controller: register scoreboard, RAW stall and branch/jump flush sequencing.
// Define R200_WB_BYPASS_EN to let a same-cycle writeback clear a RAW hazard.
module r200_hazard_ctl (
    input  logic             clk,
    input  logic             rst_n,
    r200_hazard_ctl_if.slave hz
);
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        BR_WAIT = 2'd1,
        FLUSH   = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pending_q;
    logic [31:0] set_mask;
    logic [31:0] clr_mask;
    logic [31:0] pend_view;
    logic        rs1_hit;
    logic        rs2_hit;
    logic        hazard;
    logic        br_take_now;
    logic        stall;
    logic        bubble;
    logic        flush;
    logic        redirect;
    logic        fire;

    always_comb begin
        clr_mask = '0;
        if (hz.wb_regwr)
            clr_mask[hz.wb_rdaddr] = 1'b1;
    end

`ifdef R200_WB_BYPASS_EN
    // The register file writes before it reads, so a retiring writer's value is already visible.
    assign pend_view = pending_q & ~clr_mask;
`else
    assign pend_view = pending_q;
`endif

    assign rs1_hit     = hz.id_uses_rs1 && (hz.id_rs1addr != 5'd0) && pend_view[hz.id_rs1addr];
    assign rs2_hit     = hz.id_uses_rs2 && (hz.id_rs2addr != 5'd0) && pend_view[hz.id_rs2addr];
    assign hazard      = rs1_hit || rs2_hit;
    assign br_take_now = hz.br_resolve && hz.br_taken;

    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        stall    = 1'b0;
        bubble   = 1'b1;
        flush    = 1'b0;
        redirect = 1'b0;
        fire     = 1'b0;
        if (rst_n) begin
            unique case (state)
                RUN: begin
                    if (hz.id_valid) begin
                        stall  = hazard;
                        bubble = hazard;
                        fire   = !hazard;
                    end
                end
                BR_WAIT: begin
                    // Release the PC on a taken resolve so it can load the branch target.
                    stall    = !br_take_now;
                    redirect = br_take_now;
                end
                FLUSH: flush = 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        set_mask = '0;
        if (fire && hz.id_regwr && (hz.id_rdaddr != 5'd0))
            set_mask[hz.id_rdaddr] = 1'b1;
    end

    // NOTE: state and scoreboard are sequential, so they use non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the scoreboard is control state, not storage, so it must be cleared on reset.
            state     <= RUN;
            pending_q <= '0;
        end else begin
            // Set is applied after clear so a fresh writer outlives an older retiring one.
            pending_q <= ((pending_q & ~clr_mask) | set_mask) & ~32'h1;
            unique case (state)
                RUN: begin
                    if (fire && hz.id_willjmp)
                        state <= FLUSH;
                    else if (fire && hz.id_isbr)
                        state <= BR_WAIT;
                end
                BR_WAIT: begin
                    if (hz.br_resolve)
                        state <= hz.br_taken ? FLUSH : RUN;
                end
                FLUSH:   state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

    assign hz.stall    = stall;
    assign hz.bubble   = bubble;
    assign hz.flush    = flush;
    assign hz.redirect = redirect;
    assign hz.id_fire  = fire;
    assign hz.pending  = pending_q;
endmodule

// File: tb/tb_r200_hazard_ctl.sv
// Directed bench for r200_hazard_ctl: cycle table for scoreboard/FSM plus hand-written reset sequences.
// Expectations follow R200_WB_BYPASS_EN when the bench is built with it defined.
module tb_r200_hazard_ctl;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    r200_hazard_ctl_if bus ();

    r200_hazard_ctl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef R200_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    // Control outputs packed as {stall, bubble, flush, redirect, id_fire}.
    localparam logic [4:0] IDLE_O  = 5'b01000;
    localparam logic [4:0] FIRE_O  = 5'b00001;
    localparam logic [4:0] STALL_O = 5'b11000;
    localparam logic [4:0] FLUSH_O = 5'b01100;
    localparam logic [4:0] REDIR_O = 5'b01010;

    typedef struct {
        logic        valid;
        logic [4:0]  rs1;
        logic        u1;
        logic [4:0]  rs2;
        logic        u2;
        logic [4:0]  rd;
        logic        regwr;
        logic        isbr;
        logic        jmp;
        logic        res;
        logic        tkn;
        logic        wbwr;
        logic [4:0]  wbrd;
        logic [4:0]  exp_ctl;
        logic [31:0] exp_pend;
        logic        skip_stall;
    } vec_t;

    vec_t vecs[37];

    function automatic vec_t mk(input logic valid, input logic [4:0] rs1, input logic u1,
                                input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                                input logic regwr, input logic isbr, input logic jmp,
                                input logic res, input logic tkn, input logic wbwr,
                                input logic [4:0] wbrd, input logic [4:0] exp_ctl,
                                input logic [31:0] exp_pend, input logic skip_stall);
        vec_t v;
        v.valid = valid; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
        v.rd = rd; v.regwr = regwr; v.isbr = isbr; v.jmp = jmp;
        v.res = res; v.tkn = tkn; v.wbwr = wbwr; v.wbrd = wbrd;
        v.exp_ctl = exp_ctl; v.exp_pend = exp_pend; v.skip_stall = skip_stall;
        return v;
    endfunction

    task automatic apply(input vec_t v);
        bus.id_valid    = v.valid;
        bus.id_rs1addr  = v.rs1;
        bus.id_uses_rs1 = v.u1;
        bus.id_rs2addr  = v.rs2;
        bus.id_uses_rs2 = v.u2;
        bus.id_rdaddr   = v.rd;
        bus.id_regwr    = v.regwr;
        bus.id_isbr     = v.isbr;
        bus.id_willjmp  = v.jmp;
        bus.br_resolve  = v.res;
        bus.br_taken    = v.tkn;
        bus.wb_regwr    = v.wbwr;
        bus.wb_rdaddr   = v.wbrd;
    endtask

    function automatic logic [36:0] observed();
        return {bus.stall, bus.bubble, bus.flush, bus.redirect, bus.id_fire, bus.pending};
    endfunction

    task automatic check(input string name, input logic [36:0] act, input logic [36:0] exp,
                         input logic [36:0] mask);
        n_tests++;
        if ((act & mask) !== (exp & mask)) begin
            n_fail++;
            $display("FAIL %s: got ctl=%05b pend=%08h, want ctl=%05b pend=%08h",
                     name, act[36:32], act[31:0], exp[36:32], exp[31:0]);
        end
    endtask

    task automatic step_check(input string name, input vec_t v);
        logic [36:0] mask;
        @(posedge clk);
        #1 apply(v);
        @(negedge clk);
        mask = v.skip_stall ? {1'b0, 36'hF_FFFF_FFFF} : {37{1'b1}};
        check(name, observed(), {v.exp_ctl, v.exp_pend}, mask);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t nop;
        vec_t tmp;
        n_tests = 0;
        n_fail  = 0;
        nop = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE_O, 0, 0);

        //        vld rs1 u1 rs2 u2 rd rw br jp rs tk wb wbrd  ctl                  pending
        vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE_O, 32'h0, 0);
        vecs[1]  = mk(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0, FIRE_O, 32'h0, 0);
        vecs[2]  = mk(1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0, 0, 0, STALL_O, 32'h20, 0);
        vecs[3]  = mk(1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0, 0, 0, STALL_O, 32'h20, 0);
        vecs[4]  = mk(1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0, 1, 5, BYP ? FIRE_O : STALL_O, 32'h20, 0);
        vecs[5]  = mk(1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0, 0, 0, FIRE_O, BYP ? 32'h40 : 32'h0, 0);
        vecs[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE_O, 32'h40, 0);
        vecs[7]  = mk(1, 0, 0, 0, 0, 6, 1, 0, 0, 0, 0, 1, 6, FIRE_O, 32'h40, 0);
        vecs[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6, IDLE_O, 32'h40, 0);
        vecs[9]  = mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, FIRE_O, 32'h0, 0);
        vecs[10] = mk(1, 0, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, FIRE_O, 32'h0, 0);
        vecs[11] = mk(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, FIRE_O, 32'h0, 0);
        vecs[12] = mk(1, 3, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, FIRE_O, 32'h8, 0);
        vecs[13] = mk(1, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, STALL_O, 32'h8, 0);
        vecs[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, IDLE_O, 32'h8, 0);
        vecs[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE_O, 32'h0, 0);
        // Taken branch: two wait cycles, redirect on resolve, one flush, back to RUN.
        vecs[16] = mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, FIRE_O, 32'h0, 0);
        vecs[17] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, STALL_O, 32'h0, 0);
        vecs[18] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, STALL_O, 32'h0, 0);
        vecs[19] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, REDIR_O, 32'h0, 1);
        vecs[20] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, FLUSH_O, 32'h0, 0);
        vecs[21] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, FIRE_O, 32'h0, 0);
        // Not-taken branch.
        vecs[22] = mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, FIRE_O, 32'h0, 0);
        vecs[23] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, STALL_O, 32'h0, 0);
        vecs[24] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, FIRE_O, 32'h0, 0);
        // jal x1 (isbr also set, jump wins), then a jump to x0.
        vecs[25] = mk(1, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, FIRE_O, 32'h0, 0);
        vecs[26] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, FLUSH_O, 32'h2, 0);
        vecs[27] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, IDLE_O, 32'h2, 0);
        vecs[28] = mk(1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, FIRE_O, 32'h0, 0);
        vecs[29] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, FLUSH_O, 32'h0, 0);
        // Hazards hold back branch and jump issue.
        vecs[30] = mk(1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 0, 0, FIRE_O, 32'h0, 0);
        vecs[31] = mk(1, 4, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, STALL_O, 32'h10, 0);
        vecs[32] = mk(1, 0, 0, 4, 1, 0, 0, 0, 1, 0, 0, 0, 0, STALL_O, 32'h10, 0);
        vecs[33] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4, IDLE_O, 32'h10, 0);
        vecs[34] = mk(1, 4, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, FIRE_O, 32'h0, 0);
        vecs[35] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, STALL_O, 32'h0, 0);
        vecs[36] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, IDLE_O, 32'h0, 0);

        // Outputs during reset, with a valid instruction presented.
        rst_n = 1'b0;
        tmp = nop;
        tmp.valid = 1'b1;
        apply(tmp);
        #2 check("reset_outputs", observed(), {IDLE_O, 32'h0}, {37{1'b1}});
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 37; i++)
            step_check($sformatf("vec%0d", i), vecs[i]);

        // Reset in BR_WAIT with x2 and x5 pending.
        tmp = nop; tmp.valid = 1'b1; tmp.regwr = 1'b1; tmp.rd = 5'd2; tmp.exp_ctl = FIRE_O;
        step_check("rst_seq_set_x2", tmp);
        tmp.rd = 5'd5; tmp.exp_pend = 32'h4;
        step_check("rst_seq_set_x5", tmp);
        tmp = nop; tmp.valid = 1'b1; tmp.isbr = 1'b1; tmp.exp_ctl = FIRE_O; tmp.exp_pend = 32'h24;
        step_check("rst_seq_branch", tmp);
        tmp = nop; tmp.valid = 1'b1; tmp.exp_ctl = STALL_O; tmp.exp_pend = 32'h24;
        step_check("rst_seq_br_wait", tmp);
        #1 rst_n = 1'b0;
        #1 check("rst_in_br_wait", observed(), {IDLE_O, 32'h0}, {37{1'b1}});
        @(negedge clk);
        rst_n = 1'b1;
        tmp = nop; tmp.valid = 1'b1; tmp.res = 1'b1; tmp.tkn = 1'b1;
        tmp.exp_ctl = FIRE_O; tmp.exp_pend = 32'h0;
        step_check("after_rst_br_wait", tmp);

        // Reset in FLUSH.
        tmp = nop; tmp.valid = 1'b1; tmp.jmp = 1'b1; tmp.exp_ctl = FIRE_O;
        step_check("rst_seq_jump", tmp);
        tmp = nop; tmp.valid = 1'b1; tmp.exp_ctl = FLUSH_O;
        step_check("rst_seq_flush", tmp);
        #1 rst_n = 1'b0;
        #1 check("rst_in_flush", observed(), {IDLE_O, 32'h0}, {37{1'b1}});
        @(negedge clk);
        rst_n = 1'b1;
        tmp = nop; tmp.valid = 1'b1; tmp.exp_ctl = FIRE_O;
        step_check("after_rst_flush", tmp);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/r200_hazard_ctl.md
R200_HAZARD_CTL -- requirements
Module: r200_hazard_ctl

Interface
REQ-001 SHALL have ports, clock and reset first: clk  in  1  pipeline clock, rising edge.
REQ-002 rst_n  in  1  reset; asynchronous assert, active-low.
REQ-003 id_valid  in  1  ID stage holds a valid instruction.
REQ-004 id_rs1addr, id_rs2addr  in  5 each  source register addresses; the rs2 address is post-rs2addrsel.
REQ-005 id_uses_rs1, id_uses_rs2  in  1 each  the source is actually read.
REQ-006 id_rdaddr  in  5  destination address after wasel; id_regwr  in  1  ID instruction writes the register file.
REQ-007 id_isbr  in  1  conditional branch; id_willjmp  in  1  unconditional jump.
REQ-008 br_resolve  in  1  branch outcome valid this cycle; br_taken  in  1  outcome (branchif).
REQ-009 wb_regwr  in  1  writeback strobe; wb_rdaddr  in  5  writeback address.
REQ-010 stall  out  1  hold PC and IF/ID register.
REQ-011 bubble  out  1  force NOP into ID/EX: regwr, memwr and isbr are suppressed.
REQ-012 flush  out  1  kill the IF/ID contents.
REQ-013 redirect  out  1  select pc_brtarg as next PC.
REQ-014 id_fire  out  1  ID instruction issues this cycle.
REQ-015 pending  out  32  register scoreboard; bit 0 is always 0.

Function
REQ-016 hazard SHALL be 1 when (id_uses_rs1 and pending[id_rs1addr]) or (id_uses_rs2 and pending[id_rs2addr]), with address 0 never hazarding.
REQ-017 FSM states SHALL be RUN, BR_WAIT and FLUSH, encoded 2 bits, with RUN as the reset state.
REQ-018 In RUN with id_valid=1: stall=hazard, bubble=hazard, and id_fire=id_valid and not hazard; all outputs are combinational from state and inputs.
REQ-019 On id_fire with id_regwr=1 and id_rdaddr!=0, pending[id_rdaddr] SHALL set at the next edge.
REQ-020 wb_regwr=1 SHALL clear pending[wb_rdaddr] at the next edge.
REQ-021 Set and clear of the same bit in one cycle SHALL leave the bit set (newer writer wins).
REQ-022 id_fire with id_isbr=1: RUN->BR_WAIT.
REQ-023 In BR_WAIT: stall=1, bubble=1, id_fire=0 until br_resolve=1.
REQ-024 br_resolve with br_taken=1: redirect=1 that cycle, then BR_WAIT->FLUSH.
REQ-025 br_resolve with br_taken=0: BR_WAIT->RUN, no redirect.
REQ-026 id_fire with id_willjmp=1: RUN->FLUSH; redirect is driven by the datapath pcsel, not by this block.
REQ-027 FLUSH SHALL last exactly one cycle with flush=1, bubble=1, stall=0 and id_fire=0, then FLUSH->RUN.
REQ-028 br_resolve in RUN or FLUSH SHALL be ignored.
REQ-029 id_isbr and id_willjmp both set: jump takes priority (RUN->FLUSH).
REQ-030 id_valid=0 in RUN: stall=0, bubble=1, id_fire=0.
REQ-031 A hazard SHALL block branch and jump issue exactly as it blocks any other instruction.

Reset
REQ-032 rst_n=0 SHALL asynchronously force state=RUN and pending=0.
REQ-033 While rst_n=0, outputs SHALL be stall=0, bubble=1, flush=0, redirect=0 and id_fire=0.
REQ-034 Reset asserted mid-BR_WAIT or mid-FLUSH SHALL abandon the branch; the first cycle after deassert is RUN with an empty scoreboard.

Configuration
REQ-035 Macro R200_WB_BYPASS_EN SHALL select whether same-cycle writeback removes a hazard.
REQ-036 With R200_WB_BYPASS_EN defined: a source whose pending bit is cleared this cycle by wb_regwr/wb_rdaddr SHALL NOT hazard; the register-file write-before-read supplies the data.
REQ-037 With R200_WB_BYPASS_EN undefined: hazard SHALL use the registered pending bit only, costing one extra stall cycle.

Verification
REQ-038 Issue addi x5 (rd=5, regwr), then add rs1=5 with no WB -> stall=1, bubble=1 until wb_regwr/wb_rdaddr=5; pending[5] goes 1 then 0.
REQ-039 Bypass check: dependent on x5 in the same cycle wb_rdaddr=5 -> stall=0 with R200_WB_BYPASS_EN, stall=1 for one cycle without it.
REQ-040 Branch issue, br_resolve=1 and br_taken=1 after 2 cycles -> BR_WAIT 2 cycles (stall=1), redirect pulse, then one FLUSH cycle, then RUN.
REQ-041 Branch with br_taken=0 -> BR_WAIT then RUN; flush and redirect stay 0.
REQ-042 Jump with rd=1 (jal) -> pending[1]=1 and one flush cycle; rd=0 writes never set pending.
REQ-043 Assert rst_n=0 during BR_WAIT with pending=0x0000_0024 -> immediate RUN, pending=0, stall=0; no redirect after release.
